// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_ctrl_if
//  Brief    : Bundle of the two requester ports, the flush input and the
//             instruction-ROM line port of the fetch controller.
//  Revision : 1.0 - initial release
// ============================================================================
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 32
);
    // requester 0 (IF stage)
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [31:0]       rsp0_data;
    // requester 1 (loader / rodata)
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [31:0]       rsp1_data;
    // line-buffer invalidate (fence.i)
    logic              flush;
    // instruction ROM line port
    logic              rom_read_op;
    logic [ADDR_W-1:0] rom_addr;
    logic [255:0]      rom_inst;

    // environment side: requesters, flush source and the ROM itself
    modport master (
        output req0_valid, req0_addr,
        input  req0_ready, rsp0_valid, rsp0_data,
        output req1_valid, req1_addr,
        input  req1_ready, rsp1_valid, rsp1_data,
        output flush,
        input  rom_read_op, rom_addr,
        output rom_inst
    );

    // controller side
    modport slave (
        input  req0_valid, req0_addr,
        output req0_ready, rsp0_valid, rsp0_data,
        input  req1_valid, req1_addr,
        output req1_ready, rsp1_valid, rsp1_data,
        input  flush,
        output rom_read_op, rom_addr,
        input  rom_inst
    );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_ctrl
//  Brief    : Two-port round-robin front end for the 8-word-line instruction
//             ROM with a single tagged 256-bit line buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int FILL_WAIT = 0
) (
    input wire               CLK,
    input wire               RST,
    inst_fetch_ctrl_if.slave bus
);
    localparam int         TAG_W       = ADDR_W - 5;
    localparam logic [3:0] C_FILL_WAIT = 4'(FILL_WAIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_line_valid;
    logic [TAG_W-1:0]    r_line_tag;
    logic [255:0]        r_line_data;
    logic                r_rr;
    logic [ADDR_W-1:2]   r_addr;
    logic                r_port;
    logic [3:0]          r_cnt;
    logic                r_flush_pend;

    logic                w_both;
    logic                w_any;
    logic                w_grant;
    logic [ADDR_W-1:2]   w_req_addr;
    logic                w_hit;
    logic                w_accept;
    logic                w_fill_done;
    logic [31:0]         w_word;
    logic                w_unused_addr_lsbs;

    // Byte-offset bits never matter for a word fetch.
    assign w_unused_addr_lsbs = ^{bus.req0_addr[1:0], bus.req1_addr[1:0]};

    // Arbitration, hit detection and next-state selection.
    always_comb begin
        w_both      = bus.req0_valid & bus.req1_valid;
        w_any       = bus.req0_valid | bus.req1_valid;
        w_grant     = w_both ? r_rr : bus.req1_valid;
        w_req_addr  = w_grant ? bus.req1_addr[ADDR_W-1:2] : bus.req0_addr[ADDR_W-1:2];
        w_hit       = r_line_valid && (r_line_tag == w_req_addr[ADDR_W-1:5]);
        w_accept    = (r_state == ST_IDLE) && w_any && !RST;
        w_fill_done = (r_state == ST_FILL) && (r_cnt == 4'd0);
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = w_hit ? ST_RESP : ST_FILL;
            ST_FILL: if (w_fill_done) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so nothing leaks mid-reset.
    assign w_word          = r_line_data[{r_addr[4:2], 5'b00000} +: 32];
    assign bus.req0_ready  = w_accept & ~w_grant;
    assign bus.req1_ready  = w_accept &  w_grant;
    assign bus.rom_read_op = (r_state == ST_FILL) && !RST;
    assign bus.rom_addr    = bus.rom_read_op ? {r_addr[ADDR_W-1:5], 5'b00000} : '0;
    assign bus.rsp0_valid  = (r_state == ST_RESP) && !r_port && !RST;
    assign bus.rsp1_valid  = (r_state == ST_RESP) &&  r_port && !RST;
    assign bus.rsp0_data   = bus.rsp0_valid ? w_word : 32'd0;
    assign bus.rsp1_data   = bus.rsp1_valid ? w_word : 32'd0;

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Request latch, round-robin pointer, wait counter and line buffer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_line_valid <= 1'b0;
            r_line_tag   <= '0;
            r_line_data  <= '0;
            r_rr         <= 1'b0;
            r_addr       <= '0;
            r_port       <= 1'b0;
            r_cnt        <= 4'd0;
            r_flush_pend <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr       <= w_req_addr;
                r_port       <= w_grant;
                r_cnt        <= C_FILL_WAIT;
                r_flush_pend <= 1'b0;
                if (w_both) r_rr <= ~w_grant;
            end else if ((r_state == ST_FILL) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // A flush seen anywhere in the fill must keep the new line invalid.
            if ((r_state == ST_FILL) && bus.flush) r_flush_pend <= 1'b1;
            if (w_fill_done) begin
                r_line_data  <= bus.rom_inst;
                r_line_tag   <= r_addr[ADDR_W-1:5];
                r_line_valid <= !(bus.flush || r_flush_pend);
            end
            if (bus.flush) r_line_valid <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_ctrl
//  Brief    : Directed, table-driven bench for inst_fetch_ctrl. Instance A
//             uses FILL_WAIT=2, instance B uses FILL_WAIT=5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_ctrl;
    logic        clk = 1'b0;
    logic        rst_a = 1'b1;
    logic        rst_b = 1'b1;
    logic        sel = 1'b0;
    logic        req0_valid = 1'b0;
    logic [31:0] req0_addr = '0;
    logic        req1_valid = 1'b0;
    logic [31:0] req1_addr = '0;
    logic        flush = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // ROM contents: word k of line L is (L << 12) + k
    function automatic logic [255:0] rom_line(input logic [31:0] a);
        logic [255:0] l;
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = ((a >> 5) << 12) + 32'(k);
        return l;
    endfunction

    inst_fetch_ctrl_if #(.ADDR_W(32)) ifa ();
    inst_fetch_ctrl_if #(.ADDR_W(32)) ifb ();

    assign ifa.req0_valid = req0_valid;
    assign ifa.req0_addr  = req0_addr;
    assign ifa.req1_valid = req1_valid;
    assign ifa.req1_addr  = req1_addr;
    assign ifa.flush      = flush;
    assign ifa.rom_inst   = rom_line(ifa.rom_addr);
    assign ifb.req0_valid = req0_valid;
    assign ifb.req0_addr  = req0_addr;
    assign ifb.req1_valid = req1_valid;
    assign ifb.req1_addr  = req1_addr;
    assign ifb.flush      = flush;
    assign ifb.rom_inst   = rom_line(ifb.rom_addr);

    inst_fetch_ctrl #(.ADDR_W(32), .FILL_WAIT(2)) dut_a (.CLK(clk), .RST(rst_a), .bus(ifa));
    inst_fetch_ctrl #(.ADDR_W(32), .FILL_WAIT(5)) dut_b (.CLK(clk), .RST(rst_b), .bus(ifb));

    logic        s_ready0, s_ready1, s_rsp0, s_rsp1, s_rom_op;
    logic [31:0] s_d0, s_d1, s_rom_addr;
    assign s_ready0   = sel ? ifb.req0_ready  : ifa.req0_ready;
    assign s_ready1   = sel ? ifb.req1_ready  : ifa.req1_ready;
    assign s_rsp0     = sel ? ifb.rsp0_valid  : ifa.rsp0_valid;
    assign s_rsp1     = sel ? ifb.rsp1_valid  : ifa.rsp1_valid;
    assign s_d0       = sel ? ifb.rsp0_data   : ifa.rsp0_data;
    assign s_d1       = sel ? ifb.rsp1_data   : ifa.rsp1_data;
    assign s_rom_op   = sel ? ifb.rom_read_op : ifa.rom_read_op;
    assign s_rom_addr = sel ? ifb.rom_addr    : ifa.rom_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        else             n_pass++;
    endtask

    // One request: wait for grant, then follow it to its response.
    task automatic xact(input int port, input logic [31:0] addr, input int flush_at,
                        output int lat, output int rom_cyc, output int bad_addr,
                        output int rsp_port, output logic [31:0] data, output int other_nz);
        logic [31:0] line_a;
        bit acc;
        line_a = {addr[31:5], 5'b00000};
        lat = -1; rom_cyc = 0; bad_addr = 0; rsp_port = -1; data = '0; other_nz = 0; acc = 0;
        @(negedge clk);
        if (port == 0) begin req0_valid = 1'b1; req0_addr = addr; end
        else           begin req1_valid = 1'b1; req1_addr = addr; end
        if (flush_at == 0) flush = 1'b1;
        for (int w = 0; w < 20; w++) begin
            #1;
            if ((port == 0) ? s_ready0 : s_ready1) begin acc = 1; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; flush = 1'b0;
        if (acc) begin
            for (int c = 1; c <= 30; c++) begin
                flush = (c == flush_at);
                #1;
                if (s_rom_op) begin
                    rom_cyc++;
                    if (s_rom_addr !== line_a) bad_addr++;
                end
                if (s_rsp0 || s_rsp1) begin
                    lat      = c;
                    rsp_port = s_rsp1 ? 1 : 0;
                    data     = s_rsp1 ? s_d1 : s_d0;
                    other_nz = s_rsp1 ? int'(s_d0 != 0) : int'(s_d1 != 0);
                    break;
                end
                @(negedge clk);
            end
        end
        flush = 1'b0;
    endtask

    typedef struct {
        int          port;
        logic [31:0] addr;
        int          pre_flush;
        int          flush_at;
        int          exp_lat;
        int          exp_rom;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vt [12];

    task automatic run_vec(input int i);
        int lat, rc, bad, rp, onz;
        logic [31:0] d;
        if (vt[i].pre_flush != 0) begin
            @(negedge clk); flush = 1'b1;
            @(negedge clk); flush = 1'b0;
        end
        xact(vt[i].port, vt[i].addr, vt[i].flush_at, lat, rc, bad, rp, d, onz);
        chk($sformatf("v%0d_latency", i),   32'(lat), 32'(vt[i].exp_lat));
        chk($sformatf("v%0d_rom_cycles", i), 32'(rc), 32'(vt[i].exp_rom));
        chk($sformatf("v%0d_rom_addr", i),  32'(bad), 32'd0);
        chk($sformatf("v%0d_rsp_port", i),  32'(rp),  32'(vt[i].port));
        chk($sformatf("v%0d_rsp_data", i),  d,        vt[i].exp_data);
        chk($sformatf("v%0d_idle_data", i), 32'(onz), 32'd0);
    endtask

    initial begin
        int grants [4];
        int rids [4];
        logic [31:0] rdat [4];
        int ng, nr, both_rdy, nrsp_b;
        int lat, rc, bad, rp, onz;
        logic [31:0] d;

        //            port addr            pre fl  lat rom data
        vt[0]  = '{0, 32'h0000_0024, 0, -1, 4, 3, 32'h0000_1001};
        vt[1]  = '{0, 32'h0000_003C, 0, -1, 1, 0, 32'h0000_1007};
        vt[2]  = '{1, 32'h0000_0020, 0, -1, 1, 0, 32'h0000_1000};
        vt[3]  = '{1, 32'h0000_0044, 0, -1, 4, 3, 32'h0000_2001};
        vt[4]  = '{0, 32'h0000_005C, 0, -1, 1, 0, 32'h0000_2007};
        vt[5]  = '{0, 32'hFFFF_FFE8, 0, -1, 4, 3, 32'hFFFF_F002};
        vt[6]  = '{1, 32'hFFFF_FFFC, 0, -1, 1, 0, 32'hFFFF_F007};
        vt[7]  = '{1, 32'h0000_0004, 0, -1, 4, 3, 32'h0000_0001};
        vt[8]  = '{1, 32'h0000_0020, 1,  2, 4, 3, 32'h0000_1000};
        vt[9]  = '{0, 32'h0000_0024, 0, -1, 4, 3, 32'h0000_1001};
        vt[10] = '{0, 32'h0000_0028, 0,  0, 1, 0, 32'h0000_1002};
        vt[11] = '{1, 32'h0000_002C, 0, -1, 4, 3, 32'h0000_1003};

        // reset held two cycles with both requesters pushing
        req0_valid = 1'b1; req0_addr = 32'h24;
        req1_valid = 1'b1; req1_addr = 32'h28;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rst%0d_ready0", c), 32'(s_ready0), 32'd0);
            chk($sformatf("rst%0d_ready1", c), 32'(s_ready1), 32'd0);
            chk($sformatf("rst%0d_rsp", c),    32'({s_rsp1, s_rsp0}), 32'd0);
            chk($sformatf("rst%0d_rom_op", c), 32'(s_rom_op), 32'd0);
            chk($sformatf("rst%0d_rom_addr", c), s_rom_addr, 32'd0);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        rst_a = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(i);
        @(negedge clk); #1;
        chk("idle_rom_addr", s_rom_addr, 32'd0);
        chk("idle_rsp_data", s_d0 | s_d1, 32'd0);

        // contention from reset, both addresses in line 0x20
        @(negedge clk);
        rst_a = 1'b1;
        req0_valid = 1'b1; req0_addr = 32'h24;
        req1_valid = 1'b1; req1_addr = 32'h28;
        @(negedge clk); @(negedge clk);
        rst_a = 1'b0;
        ng = 0; nr = 0; both_rdy = 0;
        for (int i = 0; i < 4; i++) begin grants[i] = -1; rids[i] = -1; rdat[i] = '0; end
        for (int c = 0; c < 60; c++) begin
            #1;
            if (s_ready0 && s_ready1) both_rdy++;
            if ((s_ready0 || s_ready1) && ng < 4) begin grants[ng] = s_ready1 ? 1 : 0; ng++; end
            if ((s_rsp0 || s_rsp1) && nr < 4) begin
                rids[nr] = s_rsp1 ? 1 : 0;
                rdat[nr] = s_rsp1 ? s_d1 : s_d0;
                nr++;
            end
            if (nr == 4) break;
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_both_ready", 32'(both_rdy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr_grant%0d", i), 32'(grants[i]), 32'(i % 2));
            chk($sformatf("rr_rsp_id%0d", i), 32'(rids[i]), 32'(grants[i]));
            chk($sformatf("rr_rsp_data%0d", i), rdat[i], (i % 2 == 0) ? 32'h1001 : 32'h1002);
        end

        for (int i = 8; i < 12; i++) run_vec(i);

        // instance B: reset lands in the second FILL cycle
        @(negedge clk);
        rst_a = 1'b1; sel = 1'b1; rst_b = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 32'h24;
        #1;
        chk("b_accept", 32'(s_ready0), 32'd1);
        nrsp_b = 0;
        @(negedge clk); req0_valid = 1'b0; #1;
        if (s_rsp0 || s_rsp1) nrsp_b++;
        chk("b_fill1_rom_op", 32'(s_rom_op), 32'd1);
        @(negedge clk); rst_b = 1'b1; #1;
        if (s_rsp0 || s_rsp1) nrsp_b++;
        chk("b_rst_rom_op", 32'(s_rom_op), 32'd0);
        @(negedge clk); rst_b = 1'b0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (s_rsp0 || s_rsp1) nrsp_b++;
            @(negedge clk);
        end
        chk("b_no_rsp", 32'(nrsp_b), 32'd0);
        xact(0, 32'h24, -1, lat, rc, bad, rp, d, onz);
        chk("b_refetch_latency",    32'(lat), 32'd7);
        chk("b_refetch_rom_cycles", 32'(rc),  32'd6);
        chk("b_refetch_rom_addr",   32'(bad), 32'd0);
        chk("b_refetch_data",       d,        32'h1001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Controller that sits in front of the 8-word-line instruction ROM and shares it between two read requesters: port 0 is the IF stage and port 1 is the loader/rodata read path. It holds one 256-bit line in a tagged line buffer and serves 32-bit words from it on a hit. On a miss it sequences a ROM line read with a programmable wait, then captures the line. Requesters are arbitrated round-robin.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; matches `ADDR_WIDTH`.
- FILL_WAIT, 0, extra cycles `rom_read_op` is held before the line is captured. Legal range 0–15.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req0_valid  in  1  IF-stage read request.
- req0_addr  in  ADDR_W  byte address; bits [1:0] ignored.
- req0_ready  out  1  request 0 accepted this cycle.
- rsp0_valid  out  1  one-cycle pulse; `rsp0_data` is valid.
- rsp0_data  out  32  instruction word.
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same as port 0, for requester 1.
- flush  in  1  invalidates the line buffer (fence.i).
- rom_read_op  out  1  ROM read enable.
- rom_addr  out  ADDR_W  line-aligned ROM address.
- rom_inst  in  256  ROM line; word k is on bits [32k+31:32k].

## Operation
- State: `line_valid`, `line_tag` = addr[ADDR_W-1:5], `line_data`[255:0], round-robin pointer `rr`, latched address and port id.
- FSM states are IDLE, FILL and RESP.
- **IDLE**
  - If any `reqN_valid` is high, grant one requester and pulse its `reqN_ready` combinationally in the same cycle.
  - Latch the request address and port id.
  - Arbitration: a single valid requester is always granted. When both are valid, grant the port given by `rr`, then set `rr` to the other port.
  - Hit (`line_valid` and tag match, evaluated at accept): go to RESP.
  - Miss: load the counter with FILL_WAIT and go to FILL.
- **FILL**
  - Drive `rom_read_op`=1 and `rom_addr` = {latched tag, 5'b0}.
  - Decrement the counter each cycle.
  - In the cycle the counter is 0: capture `rom_inst` into `line_data`, set `line_tag`, set `line_valid`=1, and go to RESP.
- **RESP**
  - Pulse `rspN_valid` for the latched port, with `rspN_data` = `line_data` word addr[4:2].
  - `reqN_ready` is 0 in this state. Return to IDLE.
- Responses have no back-pressure; the consumer must take the word in the pulse cycle.
- `flush`
  - Clears `line_valid` on the next edge, in any state.
  - Flush during FILL: the line is still captured and the pending response is still served from it, but `line_valid` stays 0.
  - Flush in the same cycle as a hit accept: the accept still counts as a hit.
- Outside FILL, `rom_read_op`=0 and `rom_addr`=0.
- Unused `rspN_data` is driven to 0 whenever `rspN_valid`=0.

## Timing
- Reset values: state IDLE, `line_valid`=0, `line_tag`=0, `line_data`=0, `rr`=0 (port 0 favoured), counter 0. All outputs are 0.
- Hit latency: accept in cycle t, `rsp_valid` in cycle t+1.
- Miss latency:
  - Accept in cycle t.
  - `rom_read_op` high in cycles t+1 … t+1+FILL_WAIT.
  - `rsp_valid` in cycle t+2+FILL_WAIT.
- Throughput: at most one accept every 2 cycles. The next accept can occur in the cycle after RESP.
- `req_ready` is never high for both ports in the same cycle, and never high outside IDLE.
- RST asserted mid-FILL or mid-RESP: the transaction is abandoned, no response is issued, and all state returns to reset values on that edge.
- Address wrap at the top of the space: no special case, since tags are compared on full width.

## Test plan
- Reset: assert RST for 2 cycles with both requesters valid → `req*_ready`, `rsp*_valid`, `rom_read_op` all 0 and `rom_addr`=0 throughout reset.
- Cold miss, FILL_WAIT=2: req0 at 0x24, ROM word k = 0x1000+k.
  - Required: `rom_read_op`=1 with `rom_addr`=0x20 for exactly 3 cycles.
  - Required: `rsp0_valid` 4 cycles after accept, with data 0x1001.
- Hit: after the cold miss, req0 at 0x3C → `rsp0_valid` the next cycle with data 0x1007, and `rom_read_op` stays 0.
- Contention: both ports valid continuously from reset at addresses inside the buffered line.
  - Required grant order: 0, 1, 0, 1.
  - Required: every response id matches its grant.
- Flush:
  - Flush, then req1 at 0x20 → a miss is taken (ROM read issued).
  - Flush asserted during that FILL → response still delivered, and the next req to 0x20 misses again.
- Reset mid-fill: with FILL_WAIT=5, assert RST in the 2nd FILL cycle → no `rsp*_valid` ever appears, and a subsequent request to the same line misses.
